// File: rtl/updown_cnt_pkg.sv
// Shared types and constants for the up/down counter command front-end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t       - front-end FSM states (IDLE, DEBOUNCE, FIRE, HOLD)
//   DIR_UP/DOWN   - encoding of the up_down direction bit
//   CTR_W         - width of the debounce and auto-repeat counters
//   press_blocked - true when a press in the given direction would wrap the counter
package updown_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        FIRE     = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Wide enough for DEBOUNCE_CYCLES and REPEAT_CYCLES up to 255.
    localparam int CTR_W = 8;

    // A press is blocked when it would step the counter past its limit in
    // the requested direction.
    function automatic logic press_blocked(input logic dir,
                                           input logic at_max,
                                           input logic at_min);
        return (dir == DIR_UP) ? at_max : at_min;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser bringing a raw asynchronous button into the clk domain.
// Latency: 2 clk edges from a stable raw level to btn_s.
// Backpressure: none; free-running sampler.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset, clears both flops
//   btn_raw - raw asynchronous button level
//   btn_s   - synchronised button level
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_s
);

    // First stage may go metastable; only the second stage is used downstream.
    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            meta_q <= btn_raw;
            btn_s  <= meta_q;
        end
    end

endmodule

// File: rtl/updown_cnt_ctrl.sv
// Button front-end for the up/down counter: sync, debounce, one enable pulse per press, limit guard.
// Latency: raw press stable before edge N -> enable high from edge N+2+DEBOUNCE_CYCLES for one cycle.
// Backpressure: none; the counter consumes every enable pulse, presses are dropped only by limits.
//
// Optional feature macro: AUTO_REPEAT_EN (held button re-fires every REPEAT_CYCLES+1 cycles).
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   btn_up    - raw asynchronous up button, active-high
//   btn_down  - raw asynchronous down button, active-high
//   count_in  - current counter value, used to suppress wrapping presses
//   enable    - one-cycle count-enable pulse to the counter
//   up_down   - direction to the counter (1=up, 0=down), held between pulses
//   limit_hit - one-cycle pulse when an accepted press is suppressed by a limit
//   busy      - high whenever the FSM is not IDLE
module updown_cnt_ctrl
    import updown_cnt_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_VAL         = 15,
    parameter int MIN_VAL         = 0,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic [WIDTH-1:0] count_in,
    output logic             enable,
    output logic             up_down,
    output logic             limit_hit,
    output logic             busy
);

    // Elaboration-time range guards for the counter-sized parameters.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("updown_cnt_ctrl: DEBOUNCE_CYCLES must be in 1..255");
    end
    if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > 255) begin : g_bad_repeat
        $error("updown_cnt_ctrl: REPEAT_CYCLES must be in 1..255");
    end

    localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_L = WIDTH'(MIN_VAL);
    localparam logic [CTR_W-1:0] DEB_L = CTR_W'(DEBOUNCE_CYCLES);
`ifdef AUTO_REPEAT_EN
    // rep_cnt "reaches" REPEAT_CYCLES on the edge where it would be bumped
    // to that value, so the compare is against the value one below.
    localparam logic [CTR_W-1:0] REP_LAST = CTR_W'(REPEAT_CYCLES - 1);
`endif

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic btn_up_s;
    logic btn_down_s;

    btn_sync u_sync_up (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_up),
        .btn_s   (btn_up_s)
    );

    btn_sync u_sync_down (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_down),
        .btn_s   (btn_down_s)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_next;
    logic [CTR_W-1:0] deb_cnt;
    logic [CTR_W-1:0] deb_next;
    logic             dir;
    logic             dir_next;
    logic             enable_next;
    logic             limit_next;
    logic             up_down_next;
    logic             fire_now;
`ifdef AUTO_REPEAT_EN
    logic [CTR_W-1:0] rep_cnt;
    logic [CTR_W-1:0] rep_next;
`endif

    // The latched button is the only one high; any other combination
    // (released, or the opposite button joining in) breaks the press.
    logic latched_solo;
    logic blocked;

    assign latched_solo = (dir == DIR_UP) ? (btn_up_s && !btn_down_s)
                                          : (btn_down_s && !btn_up_s);

    // count_in is judged at the same edge that enters FIRE.
    assign blocked = press_blocked(dir, count_in == MAX_L, count_in == MIN_L);

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        deb_next   = deb_cnt;
        dir_next   = dir;
        fire_now   = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_next   = '0;
`endif

        case (state)
            IDLE: begin
                if (btn_up_s ^ btn_down_s) begin
                    dir_next   = btn_up_s ? DIR_UP : DIR_DOWN;
                    deb_next   = CTR_W'(1);
                    state_next = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (latched_solo) begin
                    if (deb_cnt >= DEB_L) begin
                        fire_now = 1'b1;
                    end else begin
                        deb_next = deb_cnt + CTR_W'(1);
                    end
                end else begin
                    // Glitch or conflict: abandon silently.
                    deb_next   = '0;
                    state_next = IDLE;
                end
            end

            FIRE: begin
                state_next = HOLD;
            end

            HOLD: begin
                if (!btn_up_s && !btn_down_s) begin
                    state_next = IDLE;
                end
`ifdef AUTO_REPEAT_EN
                else if (latched_solo) begin
                    if (rep_cnt == REP_LAST) begin
                        fire_now = 1'b1;
                    end else begin
                        rep_next = rep_cnt + CTR_W'(1);
                    end
                end
`endif
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (fire_now) begin
            state_next = FIRE;
            deb_next   = '0;
        end

        // Pulses default low so they clear on the edge leaving FIRE.
        enable_next  = fire_now && !blocked;
        limit_next   = fire_now && blocked;
        up_down_next = fire_now ? dir : up_down;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            dir       <= DIR_UP;
            enable    <= 1'b0;
            limit_hit <= 1'b0;
            up_down   <= DIR_UP;
        end else begin
            state     <= state_next;
            deb_cnt   <= deb_next;
            dir       <= dir_next;
            enable    <= enable_next;
            limit_hit <= limit_next;
            up_down   <= up_down_next;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_next;
        end
    end
`endif

endmodule
